pkt_output_allocator: RTL and testbench
=======================================

Name: pkt_output_allocator

Overview:
- Per-output-port packet allocator for the mesh router. One instance per output port.
- Shares the port between up to NUM_IN input FIFOs using round-robin arbitration, and locks the port to the winner for the whole packet (wormhole).
- Drives the read enables for the input FIFOs, the crossbar select, the output-buffer enable and RTS, all paced by the downstream DCTS.

Parameters:
- NUM_IN, 5, number of requesting input ports (L,N,E,W,S order = bit 0..4).
- LEN_W, 12, width of the per-requester packet-length field, in flits including the header.
- WDOG_LIMIT, 255, consecutive stalled cycles before abort; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_IN  bit i: input i holds a routed header for this port (flowcontrol ready).
- len_in  input  NUM_IN*LEN_W  packet length of requester i at bits [i*LEN_W +: LEN_W].
- dcts  input  1  downstream clear-to-send.
- grant  output  NUM_IN  one-hot FIFO read enable, one flit per asserted cycle.
- sel  output  NUM_IN  one-hot crossbar select; registered; stable for the whole packet.
- out_en  output  1  output-buffer load enable; equals |grant.
- rts  output  1  registered request-to-send; follows out_en by one cycle.
- busy  output  1  high while a packet owns the port.
- abort  output  1  one-cycle pulse when the watchdog kills a packet.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sel=0, rts=0, busy=0, abort=0, cnt=0, rr_ptr=NUM_IN-1.
  - grant and out_en are 0 during reset.
  - Reset mid-packet drops the lock immediately. No flit is read after reset asserts.
- State IDLE: grant=0, busy=0.
  - If |req, search indices rr_ptr+1 .. rr_ptr+NUM_IN, modulo NUM_IN. The first set bit wins.
  - On the next edge: sel=onehot(winner), cnt=len_in[winner], state=XFER.
  - A length of 0 is loaded as 1.
- State XFER: busy=1.
  - fire = dcts. grant = sel & {NUM_IN{dcts}} (combinational). out_en = fire.
  - On each fire, cnt decrements.
  - If fire and cnt==1: state=IDLE, rr_ptr=index(sel), sel=0.
  - dcts=0: hold all state; grant=0.
  - req changes during XFER are ignored because the port is locked.
- Latency: req to first grant is 1 cycle when dcts=1.
  - One bubble cycle between packets (the XFER to IDLE to XFER path).
  - A packet of N flits with dcts held high occupies exactly N+1 cycles including arbitration.
- rts <= out_en, registered every cycle.
- Width rules: cnt is LEN_W bits and never underflows, because exit happens at 1.
  - rr_ptr wraps modulo NUM_IN; NUM_IN need not be a power of two.
- Simultaneous events:
  - The last-flit fire and new requests in the same cycle are arbitrated in the following IDLE cycle using the updated rr_ptr.
  - The just-served requester therefore has lowest priority.

Optional Feature:
- Macro: PKT_ALLOC_WDOG_EN.
- Defined: a stall counter clears on every fire or outside XFER, and increments in XFER while dcts=0.
  - On reaching WDOG_LIMIT: abort pulses high for 1 cycle, state=IDLE, sel=0, rr_ptr=index(owner), and the stall counter clears.
  - The remaining flits stay in the FIFO; purging them is the upstream's job.
- Not defined: the stall counter is absent, abort is tied to 0, and XFER waits for dcts indefinitely.

Test Plan:
- Single packet: req=5'b00010, len[1]=3, dcts=1 → grant=00010 for 3 consecutive cycles starting 1 cycle after req; rts high the 3 cycles after that; busy drops after the 3rd flit.
- Round-robin: req=5'b11111 held, all lengths 1, from reset → owners 0,1,2,3,4,0, each grant separated by one idle cycle.
- Backpressure: len=4, dcts toggles 1,0,0,1,1,0,1 → exactly 4 grant pulses, only on dcts=1 cycles; sel constant throughout.
- Zero length: len=0 → exactly one grant pulse, then IDLE.
- Async reset mid-packet: assert rst=0 after the 2nd of 5 flits → grant, sel, rts and busy go to 0 without a clock edge; after release the next winner is index 0.
- Watchdog (PKT_ALLOC_WDOG_EN, WDOG_LIMIT=4): dcts=0 after the header → abort pulses on the 4th stalled cycle, busy=0, the next requester is granted; without the macro the lock is held for 100 cycles and abort stays 0.

Source files
------------

// File: rtl/pkt_output_allocator.sv
// -----------------------------------------------------------------------------
// pkt_output_allocator
//
// Per-output-port packet allocator for the mesh router (one instance per
// output port). Up to NUM_IN input FIFOs compete for the port through
// round-robin arbitration. The winner keeps the port for its whole packet
// (wormhole). All flit movement is paced by the downstream clear-to-send.
//
// Optional watchdog: define PKT_ALLOC_WDOG_EN. A packet then stalls for at most
// WDOG_LIMIT consecutive cycles before it is aborted. Its remaining flits stay
// in the input FIFO. Without the macro, abort is tied low and the port waits
// for dcts indefinitely.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   req     in   [NUM_IN]        bit i: input i holds a header routed here
//   len_in  in   [NUM_IN*LEN_W]  packet length of requester i (flits incl.
//                                header); a length of 0 is treated as 1
//   dcts    in   downstream clear-to-send
//   grant   out  [NUM_IN]        one-hot FIFO read enable, one flit per cycle
//   sel     out  [NUM_IN]        one-hot crossbar select, registered
//   out_en  out  output-buffer load enable (= |grant)
//   rts     out  registered request-to-send (out_en delayed by one cycle)
//   busy    out  a packet currently owns the port
//   abort   out  one-cycle pulse when the watchdog kills a packet
// -----------------------------------------------------------------------------
module pkt_output_allocator #(
    parameter int unsigned NUM_IN     = 5,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         req,
    input  logic [NUM_IN*LEN_W-1:0]   len_in,
    input  logic                      dcts,
    output logic [NUM_IN-1:0]         grant,
    output logic [NUM_IN-1:0]         sel,
    output logic                      out_en,
    output logic                      rts,
    output logic                      busy,
    output logic                      abort
);

    localparam int unsigned IDX_W = $clog2(NUM_IN);

    if (NUM_IN < 2 || WDOG_LIMIT < 1) begin : g_param_check
        $error("pkt_output_allocator: NUM_IN must be >= 2 and WDOG_LIMIT >= 1");
    end

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IN-1:0]    sel_q, sel_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic                 rts_q;

    logic                 win_found;
    logic [NUM_IN-1:0]    win_oh;
    logic [LEN_W-1:0]     win_len;
    logic [IDX_W-1:0]     owner_idx;

    // Round-robin search starting just above rr_q: first scan the indices
    // above the pointer, then wrap around to 0..rr_q. This avoids a modulo
    // and works for any NUM_IN.
    always_comb begin
        win_found = 1'b0;
        win_oh    = '0;
        win_len   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!win_found && req[i] && (IDX_W'(i) > rr_q)) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_len   = len_in[i*LEN_W +: LEN_W];
            end
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!win_found && req[i] && (IDX_W'(i) <= rr_q)) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_len   = len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    // Index of the current owner. It becomes the new round-robin pointer, so
    // the owner just served has the lowest priority next.
    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel_q[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
    end

`ifdef PKT_ALLOC_WDOG_EN
    localparam int unsigned STALL_W = $clog2(WDOG_LIMIT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant   = '0;
`ifdef PKT_ALLOC_WDOG_EN
        stall_d = '0;
        abort_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_oh;
                    cnt_d   = (win_len == '0) ? LEN_W'(1) : win_len;
                    state_d = XFER;
                end
            end
            XFER: begin
                grant = sel_q & {NUM_IN{dcts}};
                if (dcts) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        rr_d    = owner_idx;
                    end
                end
`ifdef PKT_ALLOC_WDOG_EN
                else if (stall_q == STALL_W'(WDOG_LIMIT - 1)) begin
                    // The current cycle is the WDOG_LIMIT-th stalled one.
                    abort_d = 1'b1;
                    state_d = IDLE;
                    sel_d   = '0;
                    rr_d    = owner_idx;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= IDX_W'(NUM_IN - 1);
            rts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rts_q   <= out_en;
        end
    end

`ifdef PKT_ALLOC_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign sel    = sel_q;
    assign out_en = |grant;
    assign rts    = rts_q;
    assign busy   = (state_q == XFER);

endmodule

// File: tb/tb_pkt_output_allocator.sv
module tb_pkt_output_allocator;

    localparam int unsigned NI = 5;
    localparam int unsigned LW = 12;
`ifdef PKT_ALLOC_WDOG_EN
    localparam int unsigned WD = 4;
`else
    localparam int unsigned WD = 255;
`endif

    logic              clk;
    logic              rst;
    logic [NI-1:0]     req;
    logic [NI*LW-1:0]  len;
    logic              dcts;
    logic [NI-1:0]     grant;
    logic [NI-1:0]     sel;
    logic              out_en;
    logic              rts;
    logic              busy;
    logic              abort;

    pkt_output_allocator #(
        .NUM_IN     (NI),
        .LEN_W      (LW),
        .WDOG_LIMIT (WD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len_in (len),
        .dcts   (dcts),
        .grant  (grant),
        .sel    (sel),
        .out_en (out_en),
        .rts    (rts),
        .busy   (busy),
        .abort  (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [NI-1:0] sb[$];
    logic [NI-1:0] s_grant, s_sel;
    logic          s_oe, s_busy, s_rts, s_abort;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs already set. Samples mid-cycle,
    // retires one scoreboard entry per flit moved, then advances one cycle.
    task automatic cyc();
        logic [NI-1:0] exp;
        #3;
        s_grant = grant;
        s_sel   = sel;
        s_oe    = out_en;
        s_busy  = busy;
        s_rts   = rts;
        s_abort = abort;
        if (s_oe === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_flit", {27'd0, s_grant}, 32'd0);
            end else begin
                exp = sb.pop_front();
                check("sb_grant", {27'd0, s_grant}, {27'd0, exp});
                check("sb_sel", {27'd0, s_sel}, {27'd0, exp});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [NI-1:0] g, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) sb.push_back(g);
    endtask

    initial begin
        bit dpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b0; req = '0; len = '0; dcts = 1'b0;
        #3;
        check("rst_grant", {27'd0, grant}, 32'd0);
        check("rst_sel", {27'd0, sel}, 32'd0);
        check("rst_rts", {31'd0, rts}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_abort", {31'd0, abort}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single packet: input 1, three flits.
        req = 5'b00010; len[1*LW +: LW] = 12'd3; dcts = 1'b1;
        push_n(5'b00010, 3);
        cyc();
        check("t1_arb_busy", {31'd0, s_busy}, 32'd0);
        check("t1_arb_oe", {31'd0, s_oe}, 32'd0);
        req = '0;
        cyc();
        check("t1_first_oe", {31'd0, s_oe}, 32'd1);
        check("t1_busy", {31'd0, s_busy}, 32'd1);
        cyc();
        check("t1_rts1", {31'd0, s_rts}, 32'd1);
        cyc();
        check("t1_rts2", {31'd0, s_rts}, 32'd1);
        cyc();
        check("t1_done_busy", {31'd0, s_busy}, 32'd0);
        check("t1_rts3", {31'd0, s_rts}, 32'd1);
        check("t1_done_oe", {31'd0, s_oe}, 32'd0);
        cyc();
        check("t1_rts_off", {31'd0, s_rts}, 32'd0);
        check("t1_sb_empty", sb.size(), 32'd0);

        // Round robin from reset: all request, all length 1.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        req = 5'b11111;
        for (int unsigned i = 0; i < NI; i++) len[i*LW +: LW] = 12'd1;
        push_n(5'b00001, 1); push_n(5'b00010, 1); push_n(5'b00100, 1);
        push_n(5'b01000, 1); push_n(5'b10000, 1); push_n(5'b00001, 1);
        for (int unsigned k = 0; k < 12; k++) begin
            cyc();
            check((k % 2 == 0) ? "t2_bubble" : "t2_fire", {31'd0, s_oe}, (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        req = '0;
        cyc();
        check("t2_sb_empty", sb.size(), 32'd0);

        // Backpressure: input 2, four flits, dcts pattern 1,0,0,1,1,0,1.
        req = 5'b00100; len[2*LW +: LW] = 12'd4; dcts = 1'b1;
        push_n(5'b00100, 4);
        cyc();
        req = '0;
        for (int unsigned k = 0; k < 7; k++) begin
            dcts = dpat[k];
            cyc();
            check("t3_oe_follows_dcts", {31'd0, s_oe}, {31'd0, dpat[k]});
            check("t3_sel_stable", {27'd0, s_sel}, 32'h04);
        end
        dcts = 1'b1;
        cyc();
        check("t3_done_busy", {31'd0, s_busy}, 32'd0);
        check("t3_sb_empty", sb.size(), 32'd0);

        // Zero length: input 3, treated as a single flit.
        req = 5'b01000; len[3*LW +: LW] = 12'd0;
        push_n(5'b01000, 1);
        cyc();
        req = '0;
        cyc();
        check("t4_one_flit", {31'd0, s_oe}, 32'd1);
        cyc();
        check("t4_idle_busy", {31'd0, s_busy}, 32'd0);
        check("t4_idle_oe", {31'd0, s_oe}, 32'd0);
        check("t4_sb_empty", sb.size(), 32'd0);

        // Asynchronous reset after the second of five flits.
        req = 5'b10000; len[4*LW +: LW] = 12'd5;
        push_n(5'b10000, 2);
        cyc();
        req = '0;
        cyc();
        cyc();
        check("t5_pre_grant", {27'd0, grant}, 32'h10);
        rst = 1'b0;
        #1;
        check("t5_rst_grant", {27'd0, grant}, 32'd0);
        check("t5_rst_sel", {27'd0, sel}, 32'd0);
        check("t5_rst_rts", {31'd0, rts}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_oe", {31'd0, out_en}, 32'd0);
        check("t5_sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        req = 5'b10001; len[0*LW +: LW] = 12'd1; len[4*LW +: LW] = 12'd1;
        push_n(5'b00001, 1);
        cyc();
        req = '0;
        cyc();
        check("t5_winner0", {27'd0, s_grant}, 32'h01);
        cyc();

        // Stall: input 1 owns the port while dcts is low, input 2 waits.
        req = 5'b00110; len[1*LW +: LW] = 12'd3; len[2*LW +: LW] = 12'd1; dcts = 1'b0;
`ifdef PKT_ALLOC_WDOG_EN
        push_n(5'b00100, 1);
        cyc();
        for (int unsigned k = 0; k < 4; k++) begin
            cyc();
            check("t6_stall_abort", {31'd0, s_abort}, 32'd0);
            check("t6_stall_busy", {31'd0, s_busy}, 32'd1);
        end
        dcts = 1'b1;
        cyc();
        check("t6_abort_pulse", {31'd0, s_abort}, 32'd1);
        check("t6_abort_busy", {31'd0, s_busy}, 32'd0);
        req = 5'b00100;
        cyc();
        check("t6_abort_low", {31'd0, s_abort}, 32'd0);
        check("t6_next_grant", {27'd0, s_grant}, 32'h04);
        req = '0;
        cyc();
`else
        push_n(5'b00010, 3);
        push_n(5'b00100, 1);
        cyc();
        for (int unsigned k = 0; k < 100; k++) begin
            cyc();
            check("t6_hold_abort", {31'd0, s_abort}, 32'd0);
            check("t6_hold_busy", {31'd0, s_busy}, 32'd1);
        end
        req = 5'b00100;
        dcts = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            if (k == 4) req = '0;
            cyc();
            check("t6_no_abort", {31'd0, s_abort}, 32'd0);
        end
        check("t6_next_grant", {27'd0, s_grant}, 32'h04);
        cyc();
`endif
        check("t6_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
